// File: rtl/llc_lookup_pkg.sv
// Shared types for the LLC way-lookup pipeline: per-way state encodings
// and the packed lookup result carried through the output stage.
package llc_lookup_pkg;

    // Per-way coherence state encodings seen on in_states.
    typedef enum logic [2:0] {
        ST_INVALID = 3'd0,
        ST_VALID   = 3'd1,
        ST_SD      = 3'd4
    } llc_state_e;

    // Way fields are sized for the largest supported set (256 ways);
    // the top module zero-extends into and truncates out of them.
    localparam int LLC_MAX_WAY_BITS = 8;

    typedef struct packed {
        logic [LLC_MAX_WAY_BITS-1:0] way;
        logic                        hit;
        logic                        evict;
        logic                        hit_locked;
        logic                        no_way;
        logic [LLC_MAX_WAY_BITS-1:0] evict_ptr_next;
    } llc_result_t;

endpackage

// File: rtl/llc_rot_pri_enc.sv
// Rotating priority encoder: finds the first set bit of vec scanning
// upward from way ptr (wrapping modulo WAYS) and returns its absolute way.
module llc_rot_pri_enc #(
    parameter int WAYS     = 16,
    parameter int WAY_BITS = $clog2(WAYS)
) (
    input  logic [WAYS-1:0]     vec,
    input  logic [WAY_BITS-1:0] ptr,
    output logic [WAY_BITS-1:0] way,
    output logic                found
);

    logic [WAYS-1:0]     rot;
    logic [WAY_BITS-1:0] idx;
    logic [WAY_BITS-1:0] pos;

    // Rotate so that rotated bit r is way (r + ptr) mod WAYS, then pick the lowest set bit.
    always_comb begin
        rot = '0;
        idx = '0;
        for (int r = 0; r < WAYS; r++) begin
            idx    = WAY_BITS'(r) + ptr;
            rot[r] = vec[idx];
        end
        found = 1'b0;
        pos   = '0;
        for (int r = WAYS - 1; r >= 0; r--) begin
            if (rot[r]) begin
                found = 1'b1;
                pos   = WAY_BITS'(r);
            end
        end
    end

    // Un-rotate; the sum wraps naturally at WAY_BITS.
    assign way = pos + ptr;

endmodule

// File: rtl/llc_lookup_way_pipe.sv
// Two-stage LLC way lookup: selects hit / empty / eviction victim for a set.
// Stage 1 registers per-way class vectors, stage 2 registers the encoded result.
// Optional build macro: LLC_LOOKUP_STATS_EN adds saturating result counters.
//
// Handshake: a transfer happens on a side exactly when its valid and ready
// are both high at a rising edge; valid never depends on ready, and while
// out_valid is high and out_ready low every out_* output is held stable.
module llc_lookup_way_pipe
    import llc_lookup_pkg::*;
#(
    parameter int WAYS       = 16,
    parameter int WAY_BITS   = $clog2(WAYS),
    parameter int TAG_BITS   = 16,
    parameter int STATE_BITS = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [TAG_BITS-1:0]        in_tag,
    input  logic [WAYS*TAG_BITS-1:0]   in_tags,
    input  logic [WAYS*STATE_BITS-1:0] in_states,
    input  logic [WAY_BITS-1:0]        in_evict_ptr,
    input  logic [WAYS-1:0]            in_lock,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WAY_BITS-1:0]        out_way,
    output logic                       out_hit,
    output logic                       out_evict,
    output logic                       out_hit_locked,
    output logic                       out_no_way,
    output logic [WAY_BITS-1:0]        out_evict_ptr_next
`ifdef LLC_LOOKUP_STATS_EN
    ,
    output logic [31:0]                stat_hits,
    output logic [31:0]                stat_evicts,
    output logic [31:0]                stat_no_way
`endif
);

    localparam logic [STATE_BITS-1:0] S_INVALID = STATE_BITS'(ST_INVALID);
    localparam logic [STATE_BITS-1:0] S_VALID   = STATE_BITS'(ST_VALID);
    localparam logic [STATE_BITS-1:0] S_SD      = STATE_BITS'(ST_SD);

    // ---------------- flow control ----------------
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s1_adv;
    logic in_fire;

    assign s1_adv   = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s1_adv;
    assign in_fire  = in_valid && in_ready;

    // ---------------- stage 1 ----------------
    logic [WAYS-1:0]     s1_hit_q,   s1_hit_d;
    logic [WAYS-1:0]     s1_empty_q, s1_empty_d;
    logic [WAYS-1:0]     s1_vld_q,   s1_vld_d;
    logic [WAYS-1:0]     s1_nsd_q,   s1_nsd_d;
    logic [WAYS-1:0]     s1_lock_q,  s1_lock_d;
    logic [WAY_BITS-1:0] s1_ptr_q,   s1_ptr_d;

    // Classify every way of the incoming set; locked ways never become empty/victim candidates.
    always_comb begin
        s1_valid_d = in_fire ? 1'b1 : (s1_adv ? 1'b0 : s1_valid_q);
        s1_hit_d   = s1_hit_q;
        s1_empty_d = s1_empty_q;
        s1_vld_d   = s1_vld_q;
        s1_nsd_d   = s1_nsd_q;
        s1_lock_d  = s1_lock_q;
        s1_ptr_d   = s1_ptr_q;
        if (in_fire) begin
            for (int i = 0; i < WAYS; i++) begin
                s1_hit_d[i]   = (in_tags[i*TAG_BITS +: TAG_BITS] == in_tag) &&
                                (in_states[i*STATE_BITS +: STATE_BITS] != S_INVALID);
                s1_empty_d[i] = (in_states[i*STATE_BITS +: STATE_BITS] == S_INVALID) && !in_lock[i];
                s1_vld_d[i]   = (in_states[i*STATE_BITS +: STATE_BITS] == S_VALID) && !in_lock[i];
                s1_nsd_d[i]   = (in_states[i*STATE_BITS +: STATE_BITS] != S_SD) && !in_lock[i];
            end
            s1_lock_d = in_lock;
            s1_ptr_d  = in_evict_ptr;
        end
    end

    // ---------------- stage 2 encode ----------------
    logic                hit_found, empty_found;
    logic [WAY_BITS-1:0] hit_way, empty_way;
    logic                vld_found, nsd_found, unl_found;
    logic [WAY_BITS-1:0] vld_way, nsd_way, unl_way;
    logic [WAY_BITS-1:0] vic_way;
    logic [WAY_BITS-1:0] vic_next;

    // Plain lowest-index priority encoders for the hit and empty classes.
    always_comb begin
        hit_found   = 1'b0;
        hit_way     = '0;
        empty_found = 1'b0;
        empty_way   = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (s1_hit_q[i]) begin
                hit_found = 1'b1;
                hit_way   = WAY_BITS'(i);
            end
            if (s1_empty_q[i]) begin
                empty_found = 1'b1;
                empty_way   = WAY_BITS'(i);
            end
        end
    end

    llc_rot_pri_enc #(.WAYS(WAYS), .WAY_BITS(WAY_BITS)) u_enc_valid (
        .vec(s1_vld_q), .ptr(s1_ptr_q), .way(vld_way), .found(vld_found)
    );
    llc_rot_pri_enc #(.WAYS(WAYS), .WAY_BITS(WAY_BITS)) u_enc_notsd (
        .vec(s1_nsd_q), .ptr(s1_ptr_q), .way(nsd_way), .found(nsd_found)
    );
    llc_rot_pri_enc #(.WAYS(WAYS), .WAY_BITS(WAY_BITS)) u_enc_unlocked (
        .vec(~s1_lock_q), .ptr(s1_ptr_q), .way(unl_way), .found(unl_found)
    );

    assign vic_way  = vld_found ? vld_way : (nsd_found ? nsd_way : unl_way);
    assign vic_next = vic_way + WAY_BITS'(1);

    llc_result_t res_c;
    llc_result_t s2_res_q, s2_res_d;

    // Class priority: hit, then empty, then rotated victim, else report no way.
    always_comb begin
        res_c                = '0;
        res_c.evict_ptr_next = LLC_MAX_WAY_BITS'(s1_ptr_q);
        if (hit_found) begin
            res_c.way        = LLC_MAX_WAY_BITS'(hit_way);
            res_c.hit        = 1'b1;
            res_c.hit_locked = s1_lock_q[hit_way];
        end else if (empty_found) begin
            res_c.way = LLC_MAX_WAY_BITS'(empty_way);
        end else if (vld_found || nsd_found || unl_found) begin
            res_c.way            = LLC_MAX_WAY_BITS'(vic_way);
            res_c.evict          = 1'b1;
            res_c.evict_ptr_next = LLC_MAX_WAY_BITS'(vic_next);
        end else begin
            res_c.way    = LLC_MAX_WAY_BITS'(s1_ptr_q);
            res_c.no_way = 1'b1;
        end
    end

    // Stage 2 loads only when it is free or being drained, so a stalled result stays put.
    always_comb begin
        s2_valid_d = s1_adv ? s1_valid_q : s2_valid_q;
        s2_res_d   = (s1_adv && s1_valid_q) ? res_c : s2_res_q;
    end

    // Pipeline registers; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_hit_q   <= '0;
            s1_empty_q <= '0;
            s1_vld_q   <= '0;
            s1_nsd_q   <= '0;
            s1_lock_q  <= '0;
            s1_ptr_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_hit_q   <= s1_hit_d;
            s1_empty_q <= s1_empty_d;
            s1_vld_q   <= s1_vld_d;
            s1_nsd_q   <= s1_nsd_d;
            s1_lock_q  <= s1_lock_d;
            s1_ptr_q   <= s1_ptr_d;
            s2_valid_q <= s2_valid_d;
            s2_res_q   <= s2_res_d;
        end
    end

    assign out_valid          = s2_valid_q;
    assign out_way            = WAY_BITS'(s2_res_q.way);
    assign out_hit            = s2_res_q.hit;
    assign out_evict          = s2_res_q.evict;
    assign out_hit_locked     = s2_res_q.hit_locked;
    assign out_no_way         = s2_res_q.no_way;
    assign out_evict_ptr_next = WAY_BITS'(s2_res_q.evict_ptr_next);

    // Upper way bits of the shared struct are zero padding for smaller sets.
    logic unused_res;
    assign unused_res = ^s2_res_q;

`ifdef LLC_LOOKUP_STATS_EN
    logic [31:0] stat_hits_q,   stat_hits_d;
    logic [31:0] stat_evicts_q, stat_evicts_d;
    logic [31:0] stat_no_way_q, stat_no_way_d;
    logic        out_fire;

    assign out_fire = s2_valid_q && out_ready;

    // Saturating counters bumped on each output transfer of the matching result.
    always_comb begin
        stat_hits_d   = stat_hits_q;
        stat_evicts_d = stat_evicts_q;
        stat_no_way_d = stat_no_way_q;
        if (out_fire && s2_res_q.hit && (stat_hits_q != '1))
            stat_hits_d = stat_hits_q + 32'd1;
        if (out_fire && s2_res_q.evict && (stat_evicts_q != '1))
            stat_evicts_d = stat_evicts_q + 32'd1;
        if (out_fire && s2_res_q.no_way && (stat_no_way_q != '1))
            stat_no_way_d = stat_no_way_q + 32'd1;
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hits_q   <= '0;
            stat_evicts_q <= '0;
            stat_no_way_q <= '0;
        end else begin
            stat_hits_q   <= stat_hits_d;
            stat_evicts_q <= stat_evicts_d;
            stat_no_way_q <= stat_no_way_d;
        end
    end

    assign stat_hits   = stat_hits_q;
    assign stat_evicts = stat_evicts_q;
    assign stat_no_way = stat_no_way_q;
`endif

endmodule

// File: tb/tb_llc_lookup_way_pipe.sv
// Directed bench for llc_lookup_way_pipe with WAYS=4: hand-computed
// results flow through an expected queue checked by an output monitor.
module tb_llc_lookup_way_pipe;

    localparam int WAYS = 4;
    localparam int WB   = 2;
    localparam int TB   = 16;
    localparam int SB   = 3;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [TB-1:0]     in_tag;
    logic [WAYS*TB-1:0] in_tags;
    logic [WAYS*SB-1:0] in_states;
    logic [WB-1:0]     in_evict_ptr;
    logic [WAYS-1:0]   in_lock;
    logic              out_valid;
    logic              out_ready;
    logic [WB-1:0]     out_way;
    logic              out_hit;
    logic              out_evict;
    logic              out_hit_locked;
    logic              out_no_way;
    logic [WB-1:0]     out_evict_ptr_next;
`ifdef LLC_LOOKUP_STATS_EN
    logic [31:0]       stat_hits;
    logic [31:0]       stat_evicts;
    logic [31:0]       stat_no_way;
`endif

    llc_lookup_way_pipe #(.WAYS(WAYS), .WAY_BITS(WB), .TAG_BITS(TB), .STATE_BITS(SB)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
        .in_tags(in_tags), .in_states(in_states), .in_evict_ptr(in_evict_ptr),
        .in_lock(in_lock),
        .out_valid(out_valid), .out_ready(out_ready), .out_way(out_way),
        .out_hit(out_hit), .out_evict(out_evict), .out_hit_locked(out_hit_locked),
        .out_no_way(out_no_way), .out_evict_ptr_next(out_evict_ptr_next)
`ifdef LLC_LOOKUP_STATS_EN
        , .stat_hits(stat_hits), .stat_evicts(stat_evicts), .stat_no_way(stat_no_way)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Packed result: {way, hit, evict, hit_locked, no_way, evict_ptr_next}
    function automatic logic [7:0] mk(input logic [1:0] way, input logic hit, input logic ev,
                                      input logic hl, input logic nw, input logic [1:0] pn);
        return {way, hit, ev, hl, nw, pn};
    endfunction

    logic [7:0] obs;
    assign obs = {out_way, out_hit, out_evict, out_hit_locked, out_no_way, out_evict_ptr_next};

    // Output monitor: every transfer must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'd1, 32'd0);
            end else begin
                check("result", {24'd0, obs}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send(input logic [15:0] tag, input logic [63:0] tags, input logic [11:0] states,
                        input logic [1:0] ptr, input logic [3:0] lock, input logic [7:0] exp);
        bit ok;
        in_tag       = tag;
        in_tags      = tags;
        in_states    = states;
        in_evict_ptr = ptr;
        in_lock      = lock;
        in_valid     = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 64 && !ok; c++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) begin
            check("in_ready_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end else begin
            exp_q.push_back(exp);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(posedge clk);
        #1;
        check("drain", exp_q.size(), 32'd0);
    endtask

    // ---------------- vectors ----------------
    localparam logic [63:0] TAGS_ABCD = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    localparam logic [63:0] TAGS_SAME = {16'h5555, 16'h5555, 16'h5555, 16'h5555};
    localparam logic [63:0] TAGS_INVM = {16'h4444, 16'h3333, 16'h2222, 16'h7777};
    // states listed way3 .. way0
    localparam logic [11:0] ST_ALLV  = {3'd1, 3'd1, 3'd1, 3'd1};
    localparam logic [11:0] ST_VIVI  = {3'd0, 3'd1, 3'd0, 3'd1};
    localparam logic [11:0] ST_ALLSD = {3'd4, 3'd4, 3'd4, 3'd4};
    localparam logic [11:0] ST_NSD   = {3'd4, 3'd4, 3'd2, 3'd4};
    localparam logic [11:0] ST_PRIO  = {3'd2, 3'd1, 3'd4, 3'd2};
    localparam logic [11:0] ST_I0V   = {3'd1, 3'd1, 3'd1, 3'd0};

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_tag = '0; in_tags = '0; in_states = '0; in_evict_ptr = '0; in_lock = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_outs", {24'd0, obs}, 32'd0);
        @(posedge clk); #1;

        // Hit on way 2, then the same hit with its way locked.
        send(16'h3333, TAGS_ABCD, ST_ALLV, 2'd0, 4'b0000, mk(2'd2, 1, 0, 0, 0, 2'd0));
        send(16'h3333, TAGS_ABCD, ST_ALLV, 2'd1, 4'b0100, mk(2'd2, 1, 0, 1, 0, 2'd1));
        // Empty beats eviction; a locked empty way is skipped.
        send(16'h9999, TAGS_ABCD, ST_VIVI, 2'd0, 4'b0000, mk(2'd1, 0, 0, 0, 0, 2'd0));
        send(16'h9999, TAGS_ABCD, ST_VIVI, 2'd2, 4'b0010, mk(2'd3, 0, 0, 0, 0, 2'd2));
        // Rotated eviction wrapping past the last way.
        send(16'h9999, TAGS_ABCD, ST_ALLV, 2'd3, 4'b1000, mk(2'd0, 0, 1, 0, 0, 2'd1));
        // All SD: first unlocked way from the pointer.
        send(16'h9999, TAGS_ABCD, ST_ALLSD, 2'd2, 4'b0000, mk(2'd2, 0, 1, 0, 0, 2'd3));
        // Everything locked: no way, way reports the pointer.
        send(16'h9999, TAGS_ABCD, ST_ALLV, 2'd2, 4'b1111, mk(2'd2, 0, 0, 0, 1, 2'd2));
        // Non-SD class chosen when no VALID way exists.
        send(16'h9999, TAGS_ABCD, ST_NSD, 2'd0, 4'b0000, mk(2'd1, 0, 1, 0, 0, 2'd2));
        // VALID class beats non-SD even when non-SD comes first in rotation.
        send(16'h9999, TAGS_ABCD, ST_PRIO, 2'd3, 4'b0000, mk(2'd2, 0, 1, 0, 0, 2'd3));
        // Multiple hits: lowest valid way wins; invalid way 0 is not a hit.
        send(16'h5555, TAGS_SAME, ST_I0V, 2'd0, 4'b0000, mk(2'd1, 1, 0, 0, 0, 2'd0));
        // Tag matches only an INVALID way: treated as empty, not hit.
        send(16'h7777, TAGS_INVM, ST_I0V, 2'd1, 4'b0000, mk(2'd0, 0, 0, 0, 0, 2'd1));
        wait_drain();

        // Backpressure: two accepted, third stalls while outputs hold.
        out_ready = 1'b0;
        send(16'h3333, TAGS_ABCD, ST_ALLV, 2'd0, 4'b0000, mk(2'd2, 1, 0, 0, 0, 2'd0));
        send(16'h9999, TAGS_ABCD, ST_ALLV, 2'd3, 4'b1000, mk(2'd0, 0, 1, 0, 0, 2'd1));
        fork
            send(16'h9999, TAGS_ABCD, ST_ALLSD, 2'd2, 4'b0000, mk(2'd2, 0, 1, 0, 0, 2'd3));
            begin
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
                    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
                    check("bp_hold", {24'd0, obs}, {24'd0, mk(2'd2, 1, 0, 0, 0, 2'd0)});
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Reset with both stages full drops both requests.
        out_ready = 1'b0;
        send(16'h3333, TAGS_ABCD, ST_ALLV, 2'd0, 4'b0000, mk(2'd2, 1, 0, 0, 0, 2'd0));
        send(16'h9999, TAGS_ABCD, ST_ALLV, 2'd3, 4'b1000, mk(2'd0, 0, 1, 0, 0, 2'd1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_outs", {24'd0, obs}, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("mid_rst_no_output", exp_q.size(), 32'd0);

        // Counted batch: 5 hits, 2 evictions, 1 no-way, back to back.
        for (int k = 0; k < 5; k++)
            send(16'h2222, TAGS_ABCD, ST_ALLV, 2'(k), 4'b0000, mk(2'd1, 1, 0, 0, 0, 2'(k)));
        send(16'h9999, TAGS_ABCD, ST_ALLV, 2'd1, 4'b0000, mk(2'd1, 0, 1, 0, 0, 2'd2));
        send(16'h9999, TAGS_ABCD, ST_ALLV, 2'd3, 4'b0000, mk(2'd3, 0, 1, 0, 0, 2'd0));
        send(16'h9999, TAGS_ABCD, ST_ALLV, 2'd0, 4'b1111, mk(2'd0, 0, 0, 0, 1, 2'd0));
        wait_drain();
        @(negedge clk);
`ifdef LLC_LOOKUP_STATS_EN
        check("stat_hits", stat_hits, 32'd5);
        check("stat_evicts", stat_evicts, 32'd2);
        check("stat_no_way", stat_no_way, 32'd1);
`endif
        check("final_out_valid", {31'd0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
